ahb_sram_slave: RTL and testbench
=================================

AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the data bus width in bits; legal values are 32 or 64.
REQ-002 The block SHALL have parameter DEPTH, default 16, giving the number of DATA_W-bit words; it SHALL be a power of two.
REQ-003 The block SHALL have parameter WAIT_STATES, default 0, giving the number of HREADYOUT-low cycles inserted per OKAY transfer (0..15).
REQ-004 The block SHALL derive ADDR_W = $clog2(DEPTH) + $clog2(DATA_W/8) + 1 as a localparam; the extra bit is the out-of-range flag.
REQ-005 HCLK  in  1  the only clock; all state updates on its rising edge.
REQ-006 HRESETn  in  1  asynchronous, active-low reset.
REQ-007 HSEL  in  1  slave select.
REQ-008 HADDR  in  ADDR_W  byte address.
REQ-009 HTRANS  in  2  IDLE/BUSY/NONSEQ/SEQ.
REQ-010 HWRITE  in  1  1 = write, 0 = read.
REQ-011 HSIZE  in  3  transfer size: byte/half/word/dword.
REQ-012 HWDATA  in  DATA_W  write data, valid in the data phase.
REQ-013 HREADY  in  1  bus-level ready; the address phase is accepted only when it is high.
REQ-014 HRDATA  out  DATA_W  read data.
REQ-015 HREADYOUT  out  1  slave ready.
REQ-016 HRESP  out  1  0 = OKAY, 1 = ERROR.

Function
REQ-017 An address phase SHALL be accepted on a rising edge when HSEL=1, HREADY=1 and HTRANS is NONSEQ or SEQ; the block SHALL register HADDR, HWRITE and HSIZE on that edge.
REQ-018 IDLE or BUSY transfers, or HSEL=0, SHALL produce a zero-wait OKAY response with no memory access.
REQ-019 The FSM SHALL have the states IDLE, WAIT, ERR1 and ERR2.
- IDLE→WAIT on an accepted OKAY transfer when WAIT_STATES>0.
- IDLE→ERR1 on an accepted erroneous transfer.
- WAIT→IDLE when the wait counter reaches WAIT_STATES.
- ERR1→ERR2 unconditionally; ERR2→IDLE, or ERR2→ERR1/WAIT if a new transfer is accepted in ERR2.
REQ-020 In WAIT, HREADYOUT SHALL be 0 for exactly WAIT_STATES cycles, then 1 with HRESP=0; with WAIT_STATES=0 the data phase SHALL complete in one cycle.
REQ-021 A transfer SHALL be erroneous if HADDR[ADDR_W-1]=1, if 8·2^HSIZE > DATA_W, or if the address is unaligned to HSIZE.
REQ-022 An erroneous transfer SHALL get the two-cycle AHB ERROR response: ERR1 drives HREADYOUT=0, HRESP=1; ERR2 drives HREADYOUT=1, HRESP=1; memory is not modified.
REQ-023 A write SHALL update only the byte lanes selected by HSIZE and HADDR low bits, using HWDATA sampled on the edge where HREADYOUT=1 ends the data phase.
REQ-024 For reads, HRDATA SHALL present the full addressed word while HREADYOUT=1 in the data phase, and 0 otherwise.
REQ-025 A read whose address phase immediately follows a write data phase to the same word SHALL return the newly written data.
REQ-026 Address phases presented while HREADYOUT=0 SHALL be ignored, since the master holds them.

Reset
REQ-027 While HRESETn=0: FSM=IDLE, wait counter=0, registered address/control=0, HREADYOUT=1, HRESP=0, HRDATA=0, all memory words=0.
REQ-028 Reset asserted mid-transfer SHALL abort that transfer without modifying memory; the first accepted address phase after deassertion SHALL behave as from IDLE.

Structure
REQ-029 Package ahb_pkg SHALL hold the HTRANS, HSIZE and HRESP encodings and the FSM state enum typedef.
REQ-030 Storage SHALL be the sub-module ahb_byte_ram (DEPTH x DATA_W, per-byte write enable, combinational read); FSM, counter and decode SHALL stay in ahb_sram_slave.

Verification
REQ-031 Test: WAIT_STATES=0, write word 0xDEADBEEF at 0x04, then read 0x04 back-to-back → HRDATA=0xDEADBEEF, HREADYOUT never low.
REQ-032 Test: WAIT_STATES=3, read 0x08 → HREADYOUT low for exactly 3 cycles, then high with HRESP=0.
REQ-033 Test: byte write 0xAA at 0x0D over word 0x11223344 at 0x0C → readback 0x1122AA44.
REQ-034 Test: DEPTH=16, DATA_W=32, write to HADDR=0x40 → ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (HREADYOUT=1, HRESP=1); memory unchanged.
REQ-035 Test: unaligned halfword at 0x01 → ERROR response; dword size with DATA_W=32 → ERROR response.
REQ-036 Test: HRESETn pulsed low during WAIT of a write → HREADYOUT=1 and HRESP=0 immediately, target word reads 0.

Source files
------------

// File: rtl/ahb_pkg.sv
// AHB-Lite encodings and the SRAM slave FSM state type.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE  = 3'b000,
        HSIZE_HALF  = 3'b001,
        HSIZE_WORD  = 3'b010,
        HSIZE_DWORD = 3'b011
    } hsize_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_ERR1 = 2'b10,
        ST_ERR2 = 2'b11
    } state_e;

endpackage

// File: rtl/ahb_byte_ram.sv
// DEPTH x DATA_W storage with per-byte write enables, cleared by reset.
// Latency: write takes effect on the clock edge, read is combinational.
// Backpressure: none; every enabled write is applied.
module ahb_byte_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    localparam int NB    = DATA_W / 8,
    localparam int IW    = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [IW-1:0]     addr_i,
    input  logic [NB-1:0]     we_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int w = 0; w < DEPTH; w++) begin
                mem_q[w] <= '0;
            end
        end else begin
            for (int b = 0; b < NB; b++) begin
                if (we_i[b]) begin
                    mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: decode, wait-state FSM and two-cycle ERROR response.
// Latency: data phase completes after WAIT_STATES low cycles (1 cycle when 0); errors take 2 cycles.
// Backpressure: HREADYOUT low stalls the master; address phases seen while stalled are ignored.
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 16,
    parameter int WAIT_STATES = 0,
    localparam int ADDR_W     = $clog2(DEPTH) + $clog2(DATA_W/8) + 1
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              HSEL,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [DATA_W-1:0] HWDATA,
    input  logic              HREADY,
    output logic [DATA_W-1:0] HRDATA,
    output logic              HREADYOUT,
    output logic              HRESP
);

    localparam int NB          = DATA_W / 8;
    localparam int LB          = $clog2(NB);
    localparam int IW          = $clog2(DEPTH);
    localparam logic [2:0] MAX_SIZE = 3'(LB);
    localparam logic [3:0] WS  = 4'(WAIT_STATES);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              dp_q, dp_d;
    logic [ADDR_W-1:0] addr_q;
    logic              write_q;
    logic [2:0]        size_q;

    logic              rdy;
    logic              acc;
    logic              req_err;
    logic [2:0]        amask;
    state_e            acc_state;
    logic              acc_dp;
    logic [NB-1:0]     be;
    logic [NB-1:0]     ram_we;
    logic [DATA_W-1:0] ram_rdata;

    always_comb begin
        rdy = 1'b1;
        if (state_q == ST_WAIT) begin
            rdy = (cnt_q == WS);
        end else if (state_q == ST_ERR1) begin
            rdy = 1'b0;
        end
    end

    assign HREADYOUT = rdy;
    assign HRESP     = (state_q == ST_ERR1 || state_q == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;

    assign acc = HSEL && HREADY && rdy &&
                 (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);

    // Alignment mask for sizes up to dword; larger sizes are already size errors.
    assign amask   = 3'((8'd1 << HSIZE) - 8'd1);
    assign req_err = HADDR[ADDR_W-1] || (HSIZE > MAX_SIZE) || (|(HADDR[2:0] & amask));

    always_comb begin
        acc_state = ST_IDLE;
        acc_dp    = 1'b0;
        if (acc) begin
            if (req_err) begin
                acc_state = ST_ERR1;
            end else if (WS != 4'd0) begin
                acc_state = ST_WAIT;
                acc_dp    = 1'b1;
            end else begin
                acc_dp    = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dp_d    = dp_q;
        case (state_q)
            ST_IDLE: begin
                state_d = acc_state;
                dp_d    = acc_dp;
                cnt_d   = 4'd0;
            end
            ST_WAIT: begin
                if (cnt_q == WS) begin
                    state_d = acc_state;
                    dp_d    = acc_dp;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d   = cnt_q + 4'd1;
                end
            end
            ST_ERR1: begin
                state_d = ST_ERR2;
                dp_d    = 1'b0;
            end
            ST_ERR2: begin
                state_d = acc_state;
                dp_d    = acc_dp;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = ST_IDLE;
                dp_d    = 1'b0;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            dp_q    <= 1'b0;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dp_q    <= dp_d;
            if (acc) begin
                addr_q  <= HADDR;
                write_q <= HWRITE;
                size_q  <= HSIZE;
            end
        end
    end

    // Lanes [off, off + 2^size) within the addressed word.
    always_comb begin
        int off;
        int n;
        be  = '0;
        off = int'(addr_q[LB-1:0]);
        n   = 1 << size_q;
        for (int i = 0; i < NB; i++) begin
            be[i] = (i >= off) && (i < off + n);
        end
    end

    assign ram_we = (dp_q && write_q && rdy && !addr_q[ADDR_W-1]) ? be : '0;
    assign HRDATA = (dp_q && !write_q && rdy) ? ram_rdata : '0;

    ahb_byte_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk_i   (HCLK),
        .rst_n_i (HRESETn),
        .addr_i  (addr_q[LB +: IW]),
        .we_i    (ram_we),
        .wdata_i (HWDATA),
        .rdata_o (ram_rdata)
    );

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave: one zero-wait instance and one 3-wait instance on a shared bus.
module tb_ahb_sram_slave;

    logic        HCLK;
    logic        HRESETn;
    logic        hsel0, hsel3;
    logic [6:0]  haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        use3;
    logic [31:0] rd0, rd3;
    logic        ro0, ro3, rs0, rs3;
    logic        hready;
    logic [31:0] hrdata_m;
    logic        hresp_m;

    int checks   = 0;
    int failures = 0;

    assign hready   = use3 ? ro3 : ro0;
    assign hrdata_m = use3 ? rd3 : rd0;
    assign hresp_m  = use3 ? rs3 : rs0;

    ahb_sram_slave #(.DATA_W(32), .DEPTH(16), .WAIT_STATES(0)) u_dut0 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready),
        .HRDATA(rd0), .HREADYOUT(ro0), .HRESP(rs0)
    );

    ahb_sram_slave #(.DATA_W(32), .DEPTH(16), .WAIT_STATES(3)) u_dut3 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel3), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready),
        .HRDATA(rd3), .HREADYOUT(ro3), .HRESP(rs3)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    typedef struct {
        logic        w;
        logic [6:0]  addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic xfer(input bit d3, input bit w, input logic [6:0] a, input logic [2:0] sz,
                        input logic [31:0] wd, output logic [31:0] rd, output bit err,
                        output int waits, output bit lowresp);
        bit done;
        use3   = d3;
        hsel0  = !d3;
        hsel3  = d3;
        htrans = 2'b10;
        haddr  = a;
        hwrite = w;
        hsize  = sz;
        @(posedge HCLK); #1;
        hsel0  = 1'b0;
        hsel3  = 1'b0;
        htrans = 2'b00;
        hwdata = wd;
        waits = 0; err = 1'b0; lowresp = 1'b0; rd = '0; done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge HCLK);
            if (hready) begin
                rd   = hrdata_m;
                err  = hresp_m;
                done = 1'b1;
            end else begin
                waits++;
                if (hresp_m) lowresp = 1'b1;
            end
        end
        if (!done) chk("xfer_timeout", 32'd0, 32'd1);
        @(posedge HCLK); #1;
    endtask

    initial begin
        logic [31:0] rd;
        bit          err, lowresp;
        int          waits;

        vecs[0]  = '{1'b1, 7'h0C, 3'd2, 32'h11223344, 32'h0,        1'b0};
        vecs[1]  = '{1'b1, 7'h0D, 3'd0, 32'h0000AA00, 32'h0,        1'b0};
        vecs[2]  = '{1'b0, 7'h0C, 3'd2, 32'h0,        32'h1122AA44, 1'b0};
        vecs[3]  = '{1'b1, 7'h40, 3'd2, 32'hFFFFFFFF, 32'h0,        1'b1};
        vecs[4]  = '{1'b0, 7'h00, 3'd2, 32'h0,        32'h0,        1'b0};
        vecs[5]  = '{1'b1, 7'h01, 3'd1, 32'hFFFFFFFF, 32'h0,        1'b1};
        vecs[6]  = '{1'b0, 7'h00, 3'd2, 32'h0,        32'h0,        1'b0};
        vecs[7]  = '{1'b1, 7'h10, 3'd3, 32'hFFFFFFFF, 32'h0,        1'b1};
        vecs[8]  = '{1'b0, 7'h10, 3'd2, 32'h0,        32'h0,        1'b0};
        vecs[9]  = '{1'b1, 7'h12, 3'd1, 32'hBEEF0000, 32'h0,        1'b0};
        vecs[10] = '{1'b0, 7'h10, 3'd2, 32'h0,        32'hBEEF0000, 1'b0};
        vecs[11] = '{1'b0, 7'h13, 3'd0, 32'h0,        32'hBEEF0000, 1'b0};
        vecs[12] = '{1'b1, 7'h3F, 3'd0, 32'h5A000000, 32'h0,        1'b0};
        vecs[13] = '{1'b0, 7'h3C, 3'd2, 32'h0,        32'h5A000000, 1'b0};
        vecs[14] = '{1'b0, 7'h03, 3'd1, 32'h0,        32'h0,        1'b1};
        vecs[15] = '{1'b0, 7'h04, 3'd2, 32'h0,        32'hDEADBEEF, 1'b0};

        HRESETn = 1'b0;
        use3 = 1'b0; hsel0 = 1'b0; hsel3 = 1'b0;
        haddr = '0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd2; hwdata = '0;
        repeat (2) @(posedge HCLK);
        #1;
        chk("rst_readyout0", {31'd0, ro0}, 32'd1);
        chk("rst_resp0",     {31'd0, rs0}, 32'd0);
        chk("rst_rdata0",    rd0,          32'd0);
        chk("rst_readyout3", {31'd0, ro3}, 32'd1);
        chk("rst_rdata3",    rd3,          32'd0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(posedge HCLK); #1;

        // Write 0x04 then read it in the write's data phase.
        use3 = 1'b0; hsel0 = 1'b1; htrans = 2'b10; haddr = 7'h04; hwrite = 1'b1; hsize = 3'd2;
        @(posedge HCLK); #1;
        hwdata = 32'hDEADBEEF; hwrite = 1'b0;
        @(negedge HCLK);
        chk("b2b_wr_ready", {31'd0, ro0}, 32'd1);
        @(posedge HCLK); #1;
        hsel0 = 1'b0; htrans = 2'b00; hwdata = '0;
        @(negedge HCLK);
        chk("b2b_rd_ready", {31'd0, ro0}, 32'd1);
        chk("b2b_rd_resp",  {31'd0, rs0}, 32'd0);
        chk("b2b_rd_data",  rd0,          32'hDEADBEEF);
        @(posedge HCLK); #1;

        for (int i = 0; i < 16; i++) begin
            xfer(1'b0, vecs[i].w, vecs[i].addr, vecs[i].size, vecs[i].wdata, rd, err, waits, lowresp);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            chk($sformatf("vec%0d_resp", i), {30'd0, err, lowresp}, vecs[i].exp_err ? 32'd3 : 32'd0);
            chk($sformatf("vec%0d_waits", i), waits, vecs[i].exp_err ? 32'd1 : 32'd0);
        end

        xfer(1'b1, 1'b1, 7'h08, 3'd2, 32'hCAFEF00D, rd, err, waits, lowresp);
        chk("ws3_wr_waits", waits, 32'd3);
        chk("ws3_wr_resp", {30'd0, err, lowresp}, 32'd0);
        xfer(1'b1, 1'b0, 7'h08, 3'd2, 32'h0, rd, err, waits, lowresp);
        chk("ws3_rd_waits", waits, 32'd3);
        chk("ws3_rd_resp", {30'd0, err, lowresp}, 32'd0);
        chk("ws3_rd_data", rd, 32'hCAFEF00D);
        xfer(1'b1, 1'b1, 7'h40, 3'd2, 32'h1, rd, err, waits, lowresp);
        chk("ws3_err_waits", waits, 32'd1);
        chk("ws3_err_resp", {30'd0, err, lowresp}, 32'd3);

        // Reset pulse while a 3-wait write is stalled.
        use3 = 1'b1; hsel3 = 1'b1; htrans = 2'b10; haddr = 7'h20; hwrite = 1'b1; hsize = 3'd2;
        @(posedge HCLK); #1;
        hsel3 = 1'b0; htrans = 2'b00; hwdata = 32'h12345678;
        @(negedge HCLK);
        chk("rstw_wait_low", {31'd0, ro3}, 32'd0);
        #2 HRESETn = 1'b0;
        #1;
        chk("rstw_readyout", {31'd0, ro3}, 32'd1);
        chk("rstw_resp",     {31'd0, rs3}, 32'd0);
        @(posedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(posedge HCLK); #1;
        xfer(1'b1, 1'b0, 7'h20, 3'd2, 32'h0, rd, err, waits, lowresp);
        chk("rstw_rd_data",  rd,    32'd0);
        chk("rstw_rd_waits", waits, 32'd3);
        xfer(1'b1, 1'b0, 7'h08, 3'd2, 32'h0, rd, err, waits, lowresp);
        chk("rstw_mem_clr",  rd,    32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0t required=finish", $time);
        $fatal(1, "timeout");
    end

endmodule
